seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: n-cycle shift/subtract loop, registered Q/R, done pulse.
// Optional macro DIVZERO_CHECK_EN adds a short-circuit divide-by-zero path and the div_zero port.
module seq_divider #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] Q,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         done,
`ifdef DIVZERO_CHECK_EN
    output logic         div_zero,
`endif
    output logic [1:0]   o_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(n);

    // Handshake: a request is taken on a rising edge where start=1 and the
    // FSM is IDLE; busy covers CALC and DONE, done pulses once the next cycle.
    logic [1:0]    r_state;
    logic [n-1:0]  r_dvd;
    logic [n-1:0]  r_dvsr;
    logic [n-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic [n-1:0]  r_q;
    logic [n-1:0]  r_r;
    logic          r_done;
`ifdef DIVZERO_CHECK_EN
    logic          r_dz;
`endif

    // The remainder stays below the divisor, so it fits n bits; only the
    // shifted value and the trial subtraction need the extra bit.
    logic [n:0]    w_shift;
    logic [n:0]    w_trial;

    assign w_shift = {r_rem, r_dvd[n-1]};
    assign w_trial = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvsr  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_done  <= 1'b0;
`ifdef DIVZERO_CHECK_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd  <= A;
                        r_dvsr <= B;
                        r_rem  <= '0;
                        r_cnt  <= CW'(n - 1);
`ifdef DIVZERO_CHECK_EN
                        r_dz   <= (B == '0);
                        if (B == '0) begin
                            r_dvd   <= '1;
                            r_rem   <= A;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (!w_trial[n]) begin
                        r_rem <= w_trial[n-1:0];
                        r_dvd <= {r_dvd[n-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[n-1:0];
                        r_dvd <= {r_dvd[n-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_q     <= r_dvd;
                    r_r     <= r_rem;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Q       = r_q;
    assign R       = r_r;
    assign done    = r_done;
    assign busy    = (r_state == S_CALC) || (r_state == S_DONE);
    assign o_state = r_state;
`ifdef DIVZERO_CHECK_EN
    assign div_zero = r_dz;
`endif

endmodule
